test_port_capture: RTL and testbench

- Sits between the CPU data-memory write bus and the result checker.
- Snoops data-memory writes to the test port and byte-swaps the little-endian bus data into readable order.
- Suppresses repeated samples while a write is held across D-cache stall cycles.
- Frames the stream between the begin and end symbols and buffers words in a FIFO.
- The checker pops the FIFO through a valid/ready handshake.

---
 rtl/test_port_capture.sv | 83 ++++++++
 tb/tb_test_port_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/test_port_capture.sv
// test_port_capture: snoops test-port writes, frames BEGIN..END and queues byte-swapped words for the checker.
// Optional WATCHDOG_EN adds an ARMED-state cycle watchdog that forces DONE and sets timeout.
module test_port_capture #(
  parameter logic [29:0] TEST_PORT    = 30'hFF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          DEPTH        = 8,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        armed,
  output logic        done,
  output logic [7:0]  word_count,
  output logic        overflow,
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state, state_nx;
  logic hold, hit, push, pop, full, empty, wr_en, wd_fire;
  logic [31:0] sw;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] mem [DEPTH];
  assign sw = {data[7:0], data[15:8], data[23:16], data[31:24]};
  // hold masks the repeated wen cycles of a write stalled by the D-cache
  assign hit = wen && !hold && addr == TEST_PORT;
  assign push = state == ARMED && hit;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign pop = !empty && out_ready;
  assign wr_en = push && (!full || pop);
  assign out_valid = !empty;
  assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
`ifdef WATCHDOG_EN
  logic [15:0] wd;
  assign wd_fire = state == ARMED && wd == TIMEOUT - 16'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd <= '0;
      timeout <= 1'b0;
    end else begin
      wd <= (state == ARMED) ? wd + 16'd1 : '0;
      if (wd_fire) timeout <= 1'b1;
    end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && hit && sw == BEGIN_SYMBOL) ? ARMED :
               (state == ARMED && ((hit && sw == END_SYMBOL) || wd_fire)) ? DONE : state;
  always_comb begin
    armed = state == ARMED;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      word_count <= '0;
    end else begin
      hold <= wen;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
      word_count <= (state == IDLE && state_nx == ARMED) ? '0 :
                    (push && word_count != 8'hFF) ? word_count + 8'd1 : word_count;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sw;
endmodule

// File: tb/tb_test_port_capture.sv
// tb_test_port_capture: directed test-plan sequences plus random traffic against a queue-based reference model.
module tb_test_port_capture;
  localparam logic [31:0] BEG = 32'h00000168;
  localparam logic [31:0] ENDS = 32'hFFFFFD5D;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0, wen = 0, out_ready = 0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic out_valid, armed, done, overflow, timeout;
  logic [31:0] out_data;
  logic [7:0] word_count;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  int mode = 0, cnt = 0;
  logic m_hold = 0, m_ovf = 0;

  test_port_capture dut (.clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .armed(armed),
    .done(done), .word_count(word_count), .overflow(overflow), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {<<8{d}};
  endfunction

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_data", out_data, q.size() != 0 ? q[0] : 32'h0);
    check("armed", 32'(armed), 32'(mode == 1));
    check("done", 32'(done), 32'(mode == 2));
    check("word_count", 32'(word_count), 32'(cnt));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("timeout", 32'(timeout), 32'h0);
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; cnt = 0; m_hold = 0; m_ovf = 0;
  endtask

  // one clock: drive at negedge, advance the model, check 1 time unit after posedge
  task automatic step(input logic [29:0] a, input logic [31:0] v, input logic w, input logic r);
    logic hit, pop;
    logic [31:0] s;
    @(negedge clk);
    addr = a; data = bswap(v); wen = w; out_ready = r;
    s = v;
    hit = w && !m_hold && a == 30'hFF;
    m_hold = w;
    pop = r && q.size() != 0;
    if (mode == 0 && hit && s == BEG) begin
      mode = 1; cnt = 0;
    end else if (mode == 1 && hit) begin
      if (q.size() == DEPTH && !pop) m_ovf = 1;
      else begin
        if (pop) begin void'(q.pop_front()); pop = 0; end
        q.push_back(s);
      end
      if (cnt < 255) cnt++;
      if (s == ENDS) mode = 2;
    end
    if (pop) void'(q.pop_front());
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] v);
    step(a, v, 1, 0);
    step(a, v, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; wen = 0; out_ready = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #12;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_armed", 32'(armed), 32'h0);
    check("rst_wc", 32'(word_count), 32'h0);
    @(negedge clk); rst = 1;
    // framing
    wr(30'hFF, BEG);
    check("frame_armed", 32'(armed), 32'h1);
    wr(30'hFF, 32'h0);
    wr(30'hFF, 32'h1);
    wr(30'hFF, ENDS);
    check("frame_done", 32'(done), 32'h1);
    check("frame_wc", 32'(word_count), 32'd3);
    check("frame_w0", out_data, 32'h0);
    step(0, 0, 0, 1);
    check("frame_w1", out_data, 32'h1);
    step(0, 0, 0, 1);
    check("frame_w2", out_data, 32'hFFFFFD5D);
    step(0, 0, 0, 1);
    wr(30'hFF, BEG);
    check("done_ignores", 32'(out_valid), 32'h0);
    // stall hold and address filter
    do_reset();
    wr(30'hFF, BEG);
    repeat (4) step(30'hFF, 32'h2, 1, 0);
    step(0, 0, 0, 0);
    check("stall_wc", 32'(word_count), 32'd1);
    check("stall_data", out_data, 32'h2);
    step(0, 0, 0, 1);
    wr(30'h10, 32'h7);
    check("filter_valid", 32'(out_valid), 32'h0);
    // overflow
    do_reset();
    wr(30'hFF, BEG);
    for (int i = 0; i < 9; i++) wr(30'hFF, 32'h10 + 32'(i));
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_wc", 32'(word_count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", out_data, 32'h10 + 32'(i));
      step(0, 0, 0, 1);
    end
    // full with simultaneous pop
    do_reset();
    wr(30'hFF, BEG);
    for (int i = 0; i < 8; i++) wr(30'hFF, 32'h20 + 32'(i));
    step(30'hFF, 32'h55, 1, 1);
    step(0, 0, 0, 0);
    check("fullpop_ovf", 32'(overflow), 32'h0);
    check("fullpop_head", out_data, 32'h21);
    repeat (8) step(0, 0, 0, 1);
    // reset mid-run
    do_reset();
    wr(30'hFF, BEG);
    for (int i = 0; i < 3; i++) wr(30'hFF, 32'h30 + 32'(i));
    @(negedge clk);
    #2 rst = 0;
    model_reset();
    #1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_armed", 32'(armed), 32'h0);
    check("midrst_wc", 32'(word_count), 32'h0);
    @(negedge clk); rst = 1;
    wr(30'hFF, 32'h1);
    check("pre_begin", 32'(armed), 32'h0);
    // random traffic
    for (int n = 0; n < 6; n++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        logic [31:0] v;
        int k;
        k = $urandom_range(0, 15);
        v = k == 0 ? BEG : (k == 1 && c > 150) ? ENDS : (k < 6 ? $urandom : 32'($urandom_range(0, 9)));
        if (k == 2 && mode == 0) v = BEG;
        step($urandom_range(0, 3) == 0 ? 30'h10 : 30'hFF, v, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
      end
    end
`ifdef WATCHDOG_EN
    do_reset();
    wr(30'hFF, BEG);
    begin
      int t = 0;
      while (!done && t < 70000) begin @(posedge clk); t++; end
      #1 check("wd_done", 32'(done), 32'h1);
      check("wd_timeout", 32'(timeout), 32'h1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
